// File: rtl/comparator_pkg.sv
// comparator_pkg: shared relation and state types for the stream comparator
package comparator_pkg;
  typedef enum logic [1:0] {REL_NONE, REL_LT, REL_EQ, REL_GT} rel_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_COUNTING, ST_STABLE} cmp_state_t;
endpackage

// File: rtl/stream_comparator_if.sv
// stream_comparator_if: sample/result bundle for stream_comparator
// master drives in_valid/num_A/num_B and observes results; slave is the comparator.
interface stream_comparator_if #(
  parameter int N = 8,
  parameter int DEBOUNCE = 4,
  parameter int CW = $clog2(DEBOUNCE + 1)
);
  logic in_valid;
  logic [N-1:0] num_A;
  logic [N-1:0] num_B;
  logic out_valid;
  logic greater;
  logic lesser;
  logic equal;
  logic change;
  logic [CW-1:0] run_len;
  logic stable;
  modport master (
    output in_valid, num_A, num_B,
    input out_valid, greater, lesser, equal, change, run_len, stable
  );
  modport slave (
    input in_valid, num_A, num_B,
    output out_valid, greater, lesser, equal, change, run_len, stable
  );
endinterface

// File: rtl/comparator_core.sv
// comparator_core: combinational N-bit relation of a vs b
// Ports: a, b operands in; rel relation out. Signed when COMPARATOR_SIGNED_EN is defined.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output rel_t         rel
);
  logic lt;
`ifdef COMPARATOR_SIGNED_EN
  assign lt = $signed(a) < $signed(b);
`else
  assign lt = a < b;
`endif
  always_comb rel = (a == b) ? REL_EQ : lt ? REL_LT : REL_GT;
endmodule

// File: rtl/stream_comparator.sv
// stream_comparator: registered streaming comparator with debounced relation tracking
// Ports: clk, rst_n (sync active-low), bus (slave: samples in, flags/run_len/stable out).
// Define COMPARATOR_SIGNED_EN for two's-complement comparison.
module stream_comparator
  import comparator_pkg::*;
#(
  parameter int N = 8,
  parameter int DEBOUNCE = 4
) (
  input logic clk,
  input logic rst_n,
  stream_comparator_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  rel_t rel, rel_q;
  cmp_state_t state;
  logic [CW-1:0] run_q, run_d;
  logic out_valid_q, change_q, stable_q, same;
  comparator_core #(.N(N)) core (.a(bus.num_A), .b(bus.num_B), .rel(rel));
  // rel_q is REL_NONE in EMPTY, so the first sample always starts a fresh run of 1
  assign same = rel == rel_q;
  always_comb run_d = !same ? CW'(1) : (run_q == CW'(DEBOUNCE)) ? run_q : run_q + CW'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      rel_q <= REL_NONE;
      run_q <= '0;
      out_valid_q <= 1'b0;
      change_q <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      change_q <= bus.in_valid && state != ST_EMPTY && !same;
      if (bus.in_valid) begin
        rel_q <= rel;
        run_q <= run_d;
        stable_q <= run_d == CW'(DEBOUNCE);
        state <= (run_d == CW'(DEBOUNCE)) ? ST_STABLE : ST_COUNTING;
      end
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.greater = rel_q == REL_GT;
  assign bus.lesser = rel_q == REL_LT;
  assign bus.equal = rel_q == REL_EQ;
  assign bus.change = change_q;
  assign bus.run_len = run_q;
  assign bus.stable = stable_q;
endmodule

// File: doc/stream_comparator.md
# stream_comparator

Registered, streaming N-bit magnitude comparator. It is the sequential successor of the team's combinational N-bit comparator. Each valid sample is compared, and the one-hot greater/lesser/equal result is registered. The block also tracks how long the same relation has persisted, so it can flag a debounced "stable" result and pulse on relation changes. It sits between sampled datapath operands, such as ADC codes vs. thresholds or counter vs. limit, and downstream control logic.

## Interface
- N, default 8: operand width in bits (N ≥ 1).
- DEBOUNCE, default 4: consecutive identical relations needed to assert `stable`; legal range 1..255.
- CW, derived localparam = $clog2(DEBOUNCE+1): width of `run_len`.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- in_valid  input  1  `num_A`/`num_B` are sampled this cycle.
- num_A  input  N  operand A.
- num_B  input  N  operand B.
- out_valid  output  1  result registers were updated by a sample last cycle.
- greater  output  1  last sampled A > B.
- lesser  output  1  last sampled A < B.
- equal  output  1  last sampled A == B.
- change  output  1  one-cycle pulse: last sample's relation differs from the previous sample's.
- run_len  output  CW  consecutive samples with the current relation, saturating at DEBOUNCE.
- stable  output  1  run_len == DEBOUNCE.

## Operation
- State machine, advancing only on cycles with `in_valid`=1:
  - EMPTY: no sample since reset. First sample → COUNTING, or → STABLE if DEBOUNCE=1.
  - COUNTING: same relation → run_len+1, and → STABLE when it reaches DEBOUNCE. Different relation → run_len=1, change=1, stay in COUNTING (→ STABLE if DEBOUNCE=1).
  - STABLE: same relation → hold run_len=DEBOUNCE. Different relation → run_len=1, change=1, → COUNTING (stay STABLE if DEBOUNCE=1).
- First sample after reset: `change`=0 and run_len=1.
- `greater`/`lesser`/`equal` are one-hot after the first sample and all 0 in EMPTY.
- Cycles with `in_valid`=0:
  - result flags, run_len, stable and state hold;
  - out_valid=0 and change=0 on the next cycle.
  - Gaps do not break a run.
- Comparison is unsigned by default; see Configuration.
- run_len saturates and never wraps.
- `stable` is a registered compare of the next run_len, not a separate counter.

## Timing
- Latency: 1 cycle. A sample at edge k appears on all outputs after edge k, with out_valid=1 in cycle k+1.
- Throughput: one sample per cycle; no backpressure.
- Reset, rst_n=0 at a rising edge:
  - all outputs 0, state EMPTY;
  - overrides `in_valid` in the same cycle;
  - a reset mid-run discards the run, and the next sample is treated as the first.
- `change` is never asserted in a cycle where out_valid=0.
- At most one state transition per cycle.

## Configuration
- COMPARATOR_SIGNED_EN defined: `num_A`/`num_B` are two's complement, compared as signed.
- Undefined (default): unsigned comparison.
- Only the relation computation changes; the debounce and state logic are identical in both builds.

## Structure
- Shared package `comparator_pkg`:
  - relation typedef `rel_t` {REL_NONE, REL_LT, REL_EQ, REL_GT};
  - state typedef `cmp_state_t` {ST_EMPTY, ST_COUNTING, ST_STABLE}.
- Sub-module `comparator_core`: combinational N-bit relation (returns `rel_t`), honouring COMPARATOR_SIGNED_EN.
- The top level holds the registers, run counter and FSM.

## Test plan
All scenarios use N=8, DEBOUNCE=4.
- Reset, then idle 3 cycles → all outputs 0, out_valid=0.
- Samples A=10,B=5 for 4 consecutive cycles → greater=1 every cycle; run_len 1,2,3,4; stable=1 only after the 4th; change=0 throughout.
- Hold A=5,B=5 for 6 samples, then A=3,B=5 → equal, run_len saturates at 4 with stable=1. The final sample gives lesser=1, change=1 for one cycle, run_len=1, stable=0.
- Alternate A>B and A<B samples with `in_valid` gaps of 2 cycles → flags hold through gaps; out_valid=0 and change=0 in gap cycles; run_len is never >1.
- A=8'hFF, B=8'h01 → default build: greater=1. COMPARATOR_SIGNED_EN build: lesser=1.
- rst_n=0 for one cycle while run_len=3 and `in_valid`=1 → outputs cleared next cycle. The next sample gives run_len=1, change=0.
